// File: rtl/am_pkg.sv
// Shared definitions for 40GBASE-R alignment-marker lock: per-lane AM bytes,
// sync header, lock FSM states and the combinational AM matcher.
package am_pkg;

  localparam int unsigned AM_LANES   = 4;
  localparam int unsigned AM_BLOCK_W = 66;
  localparam int unsigned AM_ID_W    = 2;
  localparam int unsigned AM_BYTES_W = 24;
  localparam int unsigned AM_ERR_W   = 8;

  localparam logic [1:0] AM_SH = 2'b10;

  // {M2,M1,M0} per logical lane, laid out as they sit in block bits [25:2]
  localparam logic [AM_LANES-1:0][AM_BYTES_W-1:0] AM_BYTES = {
    24'h3D79A2,
    24'h9B65C5,
    24'hE6C4F0,
    24'h477690
  };

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } am_state_e;

  typedef struct packed {
    logic               hit;
    logic [AM_ID_W-1:0] id;
  } am_match_t;

  // lo = {M2,M1,M0}, hi = {M6,M5,M4}; BIP bytes never take part in the match
  function automatic am_match_t am_match(input logic [1:0]            sh,
                                         input logic [AM_BYTES_W-1:0] lo,
                                         input logic [AM_BYTES_W-1:0] hi);
    am_match_t m;
    m = '0;
    for (int j = 0; j < int'(AM_LANES); j++) begin
      if (sh == AM_SH && lo == AM_BYTES[j] && hi == ~AM_BYTES[j]) begin
        m.hit = 1'b1;
        m.id  = AM_ID_W'(j);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/am_lock_fsm.sv
// Per-physical-lane AM lock FSM: SEARCH -> CHECK -> LOCKED with period tracking.
// Optional AM_ERR_CNT_EN adds a saturating bad-AM counter while LOCKED.
module am_lock_fsm
  import am_pkg::*;
#(
  parameter int unsigned AM_PERIOD   = 16383,
  parameter int unsigned AM_LOCK_N   = 2,
  parameter int unsigned AM_UNLOCK_N = 4
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  block_v,
  input  logic [AM_BLOCK_W-1:0] blk,
  output logic                  lock_c,
  output logic [AM_ID_W-1:0]    id_c,
  output logic                  am
`ifdef AM_ERR_CNT_EN
  ,
  output logic [AM_ERR_W-1:0]   err_cnt
`endif
);

  localparam int unsigned CNT_W  = $clog2(AM_PERIOD + 1);
  localparam int unsigned GOOD_W = $clog2(AM_LOCK_N + 1);
  localparam int unsigned BAD_W  = $clog2(AM_UNLOCK_N + 1);

  am_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GOOD_W-1:0]   good_q, good_d;
  logic [BAD_W-1:0]    bad_q, bad_d;
  logic [AM_ID_W-1:0]  id_q, id_d;
  logic                am_d;
`ifdef AM_ERR_CNT_EN
  logic [AM_ERR_W-1:0] err_q, err_d;
`endif

  am_match_t m_c;
  logic      at_exp_c;
  logic      id_ok_c;
  logic      bip_unused;

  assign m_c        = am_match(blk[1:0], blk[25:2], blk[57:34]);
  assign bip_unused = ^{blk[AM_BLOCK_W-1:58], blk[33:26]};
  assign at_exp_c   = (cnt_q == CNT_W'(AM_PERIOD));
  assign id_ok_c    = m_c.hit && (m_c.id == id_q);

  // Next-state: only a valid block moves anything; the expected slot is the
  // block after cnt reaches AM_PERIOD, and only that slot is judged.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    good_d  = good_q;
    bad_d   = bad_q;
    id_d    = id_q;
    am_d    = 1'b0;
`ifdef AM_ERR_CNT_EN
    err_d   = err_q;
`endif
    if (block_v) begin
      unique case (state_q)
        SEARCH: begin
          if (m_c.hit) begin
            state_d = CHECK;
            id_d    = m_c.id;
            cnt_d   = '0;
            good_d  = '0;
          end
        end
        CHECK: begin
          if (at_exp_c) begin
            cnt_d = '0;
            if (id_ok_c) begin
              am_d   = 1'b1;
              good_d = good_q + GOOD_W'(1);
              if (good_d == GOOD_W'(AM_LOCK_N)) begin
                state_d = LOCKED;
                bad_d   = '0;
              end
            end else begin
              state_d = SEARCH;
              id_d    = '0;
              good_d  = '0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        LOCKED: begin
          if (at_exp_c) begin
            cnt_d = '0;
            if (id_ok_c) begin
              am_d  = 1'b1;
              bad_d = '0;
            end else begin
`ifdef AM_ERR_CNT_EN
              if (err_q != '1) err_d = err_q + AM_ERR_W'(1);
`endif
              bad_d = bad_q + BAD_W'(1);
              if (bad_d == BAD_W'(AM_UNLOCK_N)) begin
                state_d = SEARCH;
                id_d    = '0;
                good_d  = '0;
              end
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= SEARCH;
      cnt_q   <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      id_q    <= '0;
      am      <= 1'b0;
`ifdef AM_ERR_CNT_EN
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      id_q    <= id_d;
      am      <= am_d;
`ifdef AM_ERR_CNT_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next-state view lets the top register its map in the same cycle as the state
  assign lock_c = (state_d == LOCKED);
  assign id_c   = id_d;

`ifdef AM_ERR_CNT_EN
  assign err_cnt = err_q;
`endif

endmodule

// File: rtl/am_lane_lock.sv
// 4-lane 40GBASE-R AM lock controller: per-lane lock FSMs, onehot lane map and
// permutation check. Optional AM_ERR_CNT_EN exposes per-lane bad-AM counters.
module am_lane_lock
  import am_pkg::*;
#(
  parameter int unsigned LANE_N      = AM_LANES,
  parameter int unsigned BLOCK_W     = AM_BLOCK_W,
  parameter int unsigned AM_PERIOD   = 16383,
  parameter int unsigned AM_LOCK_N   = 2,
  parameter int unsigned AM_UNLOCK_N = 4
) (
  input  logic                        clk,
  input  logic                        nreset,
  input  logic                        block_v_i,
  input  logic [LANE_N*BLOCK_W-1:0]   block_i,
  output logic [LANE_N*LANE_N-1:0]    lane_o,
  output logic [LANE_N-1:0]           lane_lock_o,
  output logic                        align_lock_o,
  output logic [LANE_N-1:0]           am_o
`ifdef AM_ERR_CNT_EN
  ,
  output logic [LANE_N*AM_ERR_W-1:0]  am_err_cnt_o
`endif
);

  localparam int unsigned COL_W = $clog2(LANE_N + 1);

  logic [LANE_N-1:0]              lock_c;
  logic [LANE_N-1:0][AM_ID_W-1:0] id_c;
  logic [LANE_N-1:0][LANE_N-1:0]  map_c;
  logic [COL_W-1:0]               col_cnt;
  logic                           perm_c;

  for (genvar i = 0; i < int'(LANE_N); i++) begin : g_lane
    am_lock_fsm #(
      .AM_PERIOD   (AM_PERIOD),
      .AM_LOCK_N   (AM_LOCK_N),
      .AM_UNLOCK_N (AM_UNLOCK_N)
    ) u_fsm (
      .clk     (clk),
      .nreset  (nreset),
      .block_v (block_v_i),
      .blk     (block_i[i*BLOCK_W +: AM_BLOCK_W]),
      .lock_c  (lock_c[i]),
      .id_c    (id_c[i]),
      .am      (am_o[i])
`ifdef AM_ERR_CNT_EN
      ,
      .err_cnt (am_err_cnt_o[i*AM_ERR_W +: AM_ERR_W])
`endif
    );
  end

  // Row i is onehot(id) only while physical lane i is locked
  always_comb begin
    map_c = '0;
    for (int i = 0; i < int'(LANE_N); i++) begin
      if (lock_c[i]) map_c[i] = LANE_N'(1) << id_c[i];
    end
  end

  // Permutation: every logical lane claimed by exactly one physical lane
  always_comb begin
    perm_c  = 1'b1;
    col_cnt = '0;
    for (int j = 0; j < int'(LANE_N); j++) begin
      col_cnt = '0;
      for (int i = 0; i < int'(LANE_N); i++) begin
        col_cnt = col_cnt + COL_W'(map_c[i][j]);
      end
      if (col_cnt != COL_W'(1)) perm_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      lane_o       <= '0;
      lane_lock_o  <= '0;
      align_lock_o <= 1'b0;
    end else begin
      lane_o       <= map_c;
      lane_lock_o  <= lock_c;
      align_lock_o <= (&lock_c) & perm_c;
    end
  end

endmodule

// File: tb/tb_am_lane_lock.sv
// Scoreboard bench for am_lane_lock with AM_PERIOD=15; expectations are queued
// by the stimulus and checked by a negedge monitor (AM_ERR_CNT_EN optional).
module tb_am_lane_lock;

  localparam int unsigned LANE_N  = 4;
  localparam int unsigned BLOCK_W = 66;
  localparam int unsigned BUS_W   = LANE_N * BLOCK_W;

  logic                       clk = 1'b0;
  logic                       nreset;
  logic                       block_v_i;
  logic [BUS_W-1:0]           block_i;
  logic [LANE_N*LANE_N-1:0]   lane_o;
  logic [LANE_N-1:0]          lane_lock_o;
  logic                       align_lock_o;
  logic [LANE_N-1:0]          am_o;
`ifdef AM_ERR_CNT_EN
  logic [LANE_N*8-1:0]        am_err_cnt_o;
`endif

  always #5 clk = ~clk;

  am_lane_lock #(
    .LANE_N      (LANE_N),
    .BLOCK_W     (BLOCK_W),
    .AM_PERIOD   (15),
    .AM_LOCK_N   (2),
    .AM_UNLOCK_N (4)
  ) dut (
    .clk          (clk),
    .nreset       (nreset),
    .block_v_i    (block_v_i),
    .block_i      (block_i),
    .lane_o       (lane_o),
    .lane_lock_o  (lane_lock_o),
    .align_lock_o (align_lock_o),
    .am_o         (am_o)
`ifdef AM_ERR_CNT_EN
    ,
    .am_err_cnt_o (am_err_cnt_o)
`endif
  );

  typedef struct packed {
    int          when;
    logic [3:0]  lock;
    logic [15:0] map;
    logic        align;
    logic [3:0]  am;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    edge_cnt = 0;
  int    n_chk    = 0;
  int    n_pass   = 0;

  logic [23:0] am_tab [4] = '{24'h477690, 24'hE6C4F0, 24'h9B65C5, 24'h3D79A2};

  logic [3:0][1:0] ids_ident = {2'd3, 2'd2, 2'd1, 2'd0};
  logic [3:0][1:0] ids_swap  = {2'd1, 2'd3, 2'd0, 2'd2};
  logic [3:0][1:0] ids_dup   = {2'd3, 2'd2, 2'd0, 2'd0};

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [BLOCK_W-1:0] am_block(input logic [1:0] id, input logic corrupt);
    logic [23:0] m;
    m = am_tab[id];
    if (corrupt) m[7:0] = m[7:0] ^ 8'h01;
    return {8'($urandom), ~am_tab[id], 8'($urandom), m, 2'b10};
  endfunction

  function automatic logic [BUS_W-1:0] data_bus();
    logic [BUS_W-1:0] b;
    for (int i = 0; i < int'(LANE_N); i++)
      b[i*BLOCK_W +: BLOCK_W] = {32'($urandom), 32'($urandom), 2'b01};
    return b;
  endfunction

  function automatic logic [BUS_W-1:0] am_bus(input logic [3:0][1:0] ids, input logic [3:0] corrupt);
    logic [BUS_W-1:0] b;
    for (int i = 0; i < int'(LANE_N); i++)
      b[i*BLOCK_W +: BLOCK_W] = am_block(ids[i], corrupt[i]);
    return b;
  endfunction

  task automatic step(input logic v, input logic [BUS_W-1:0] bus);
    block_v_i = v;
    block_i   = bus;
    @(posedge clk);
    #1;
  endtask

  task automatic send_am(input logic [3:0][1:0] ids, input logic [3:0] corrupt);
    step(1'b1, am_bus(ids, corrupt));
  endtask

  task automatic send_data(input int n);
    repeat (n) step(1'b1, data_bus());
  endtask

  // Invalid cycles carry real AMs so a design that ignores block_v_i would react
  task automatic stall(input int n);
    repeat (n) step(1'b0, am_bus(ids_ident, 4'b0000));
  endtask

  task automatic expect_out(input string nm, input logic [3:0] lock, input logic [15:0] map,
                            input logic align, input logic [3:0] am);
    exp_t e;
    e.when  = edge_cnt;
    e.lock  = lock;
    e.map   = map;
    e.align = align;
    e.am    = am;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic do_reset(input string nm);
    nreset    = 1'b0;
    block_v_i = 1'b0;
    @(posedge clk);
    #1;
    expect_out(nm, 4'h0, 16'h0000, 1'b0, 4'h0);
    @(negedge clk);
    #1;
    nreset = 1'b1;
  endtask

  task automatic three_ams(input string pfx, input logic [3:0][1:0] ids,
                           input logic [15:0] map, input logic align);
    send_am(ids, 4'b0000);
    expect_out({pfx, "_am1"}, 4'h0, 16'h0000, 1'b0, 4'h0);
    send_data(15);
    send_am(ids, 4'b0000);
    expect_out({pfx, "_am2"}, 4'h0, 16'h0000, 1'b0, 4'hF);
    send_data(15);
    send_am(ids, 4'b0000);
    expect_out({pfx, "_am3"}, 4'hF, map, align, 4'hF);
    send_data(15);
  endtask

  exp_t  mon_e;
  string mon_n;

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].when < edge_cnt) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      n_chk++;
      $display("FAIL %s: expectation for edge %0d never sampled (now %0d)", mon_n, mon_e.when, edge_cnt);
    end
    while (exp_q.size() > 0 && exp_q[0].when == edge_cnt) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      n_chk++;
      if (lane_lock_o == mon_e.lock && lane_o == mon_e.map &&
          align_lock_o == mon_e.align && am_o == mon_e.am) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got lock=%h map=%h align=%b am=%h, expected lock=%h map=%h align=%b am=%h",
                 mon_n, lane_lock_o, lane_o, align_lock_o, am_o,
                 mon_e.lock, mon_e.map, mon_e.align, mon_e.am);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset    = 1'b0;
    block_v_i = 1'b0;
    block_i   = '0;
    do_reset("reset");

    // Identity mapping: lock one cycle after the third AM
    send_am(ids_ident, 4'b0000);
    expect_out("ident_am1", 4'h0, 16'h0000, 1'b0, 4'h0);
    send_data(15);
    send_am(ids_ident, 4'b0000);
    expect_out("ident_am2", 4'h0, 16'h0000, 1'b0, 4'hF);
    send_data(15);
    expect_out("ident_prelock", 4'h0, 16'h0000, 1'b0, 4'h0);
    send_am(ids_ident, 4'b0000);
    expect_out("ident_lock", 4'hF, 16'h8421, 1'b1, 4'hF);
    send_data(1);
    expect_out("ident_am_drop", 4'hF, 16'h8421, 1'b1, 4'h0);
    send_data(14);

    // Unlock lane 1 with four corrupted M0 bytes
    for (int k = 1; k <= 4; k++) begin
      send_am(ids_ident, 4'b0010);
      if (k == 3) expect_out("unlock_bad3", 4'hF, 16'h8421, 1'b1, 4'hD);
      if (k == 4) expect_out("unlock_bad4", 4'hD, 16'h8401, 1'b0, 4'hD);
`ifdef AM_ERR_CNT_EN
      if (k == 4) begin
        n_chk++;
        if (am_err_cnt_o == 32'h0000_0400) n_pass++;
        else $display("FAIL err_cnt: got %h, expected %h", am_err_cnt_o, 32'h0000_0400);
      end
`endif
      send_data(15);
    end

    // Recovery needs a fresh three-AM sequence on lane 1
    send_am(ids_ident, 4'b0000);
    expect_out("relock_am1", 4'hD, 16'h8401, 1'b0, 4'hD);
    send_data(15);
    send_am(ids_ident, 4'b0000);
    expect_out("relock_am2", 4'hD, 16'h8401, 1'b0, 4'hF);
    send_data(15);
    send_am(ids_ident, 4'b0000);
    expect_out("relock_am3", 4'hF, 16'h8421, 1'b1, 4'hF);
    send_data(15);

    // Stall: five invalid cycles shift the expected slot by five cycles
    send_am(ids_ident, 4'b0000);
    expect_out("stall_am", 4'hF, 16'h8421, 1'b1, 4'hF);
    stall(1);
    expect_out("stall_am_drop", 4'hF, 16'h8421, 1'b1, 4'h0);
    send_data(7);
    stall(4);
    expect_out("stall_hold", 4'hF, 16'h8421, 1'b1, 4'h0);
    send_data(8);
    send_am(ids_ident, 4'b0000);
    expect_out("stall_shifted_am", 4'hF, 16'h8421, 1'b1, 4'hF);
    send_data(15);

    do_reset("swap_reset");
    three_ams("swap", ids_swap, 16'h2814, 1'b1);

    do_reset("dup_reset");
    three_ams("dup", ids_dup, 16'h8411, 1'b0);

    // Reset mid-CHECK discards the first detection
    do_reset("mid_reset0");
    send_am(ids_ident, 4'b0000);
    send_data(5);
    do_reset("mid_reset");
    send_data(10);
    send_am(ids_ident, 4'b0000);
    expect_out("mid_am2", 4'h0, 16'h0000, 1'b0, 4'h0);
    send_data(15);
    send_am(ids_ident, 4'b0000);
    expect_out("mid_am3", 4'h0, 16'h0000, 1'b0, 4'hF);
    send_data(15);
    send_am(ids_ident, 4'b0000);
    expect_out("mid_relock", 4'hF, 16'h8421, 1'b1, 4'hF);
    send_data(2);

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      n_chk++;
      $display("FAIL %s: expectation left unchecked at end of run", mon_n);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/am_lane_lock.md
Name: am_lane_lock

Overview:
- Per-physical-lane alignment-marker (AM) lock controller for the 4-lane 40GBASE-R PCS receive path.
- Sits after block sync, ahead of the receive lane reorder stage.
- Detects AMs on each physical lane and decides which logical lane that physical lane carries.
- Drives the onehot lane map the reorder stage consumes, plus global alignment status.

Parameters:
- LANE_N, 4, number of lanes.
- BLOCK_W, 66, block width including 2-bit sync header.
- AM_PERIOD, 16383, valid blocks between consecutive AMs on one lane; reduce in simulation.
- AM_LOCK_N, 2, consecutive matching AMs after first detection required for lock.
- AM_UNLOCK_N, 4, consecutive bad AMs in LOCKED before lock is dropped.

Ports:
- clk  in  1  clock.
- nreset  in  1  asynchronous active-low reset.
- block_v_i  in  1  blocks valid this cycle, common to all lanes; counters advance only when high.
- block_i  in  LANE_N*BLOCK_W  unordered blocks; lane x at [x*BLOCK_W +: BLOCK_W].
- lane_o  out  LANE_N*LANE_N  lane map: bit [i*LANE_N+j] = physical lane i carries logical lane j.
- lane_lock_o  out  LANE_N  per-physical-lane AM lock.
- align_lock_o  out  1  all lanes locked and the map is a permutation.
- am_o  out  LANE_N  registered flag: the block accepted last valid cycle on lane i was an expected AM (downstream removal).

Behaviour:
- AM match on a block:
  - Sync header [1:0] == 2'b10.
  - M0/M1/M2 at [9:2]/[17:10]/[25:18] equal the lane-j constants:
    - lane 0: 90,76,47
    - lane 1: F0,C4,E6
    - lane 2: C5,65,9B
    - lane 3: A2,79,3D
  - M4/M5/M6 at [41:34]/[49:42]/[57:50] equal the bitwise inverse of M0/M1/M2.
  - BIP bytes are ignored.
  - Match is combinational; it yields hit and a 2-bit id.
- Per-lane FSM, evaluated only on block_v_i:
  - SEARCH: on any hit, store id, clear cnt and good, go to CHECK.
  - CHECK: cnt increments per valid block.
    - When cnt == AM_PERIOD, the next valid block is the expected AM position.
    - Hit with same id: good++, cnt=0. If good == AM_LOCK_N, go to LOCKED.
    - Otherwise go to SEARCH. Any hit at an unexpected position is ignored.
  - LOCKED: same period tracking.
    - Expected block is a hit with same id: bad=0.
    - Otherwise: bad++. If bad == AM_UNLOCK_N, go to SEARCH and clear id.
    - cnt still resets to 0 at every expected position, hit or miss.
- Counter widths:
  - cnt is $clog2(AM_PERIOD+1) bits and never wraps past AM_PERIOD.
  - good and bad saturate at their thresholds.
- block_v_i low: all FSMs, counters and am_o hold. am_o deasserts the cycle after a non-valid cycle.
- Outputs are registered; each updates one cycle after the valid block that causes the transition.
  - lane_o row i = onehot(id) when lane i LOCKED, else zero.
  - lane_lock_o[i] = state==LOCKED.
  - align_lock_o = &lane_lock_o AND every column of lane_o has exactly one bit set.
  - A duplicate id leaves align_lock_o low and both lanes keep their rows; no forced relock.
- Reset (async assert, sync release by upstream): all FSMs SEARCH, counters 0, lane_o=0, lane_lock_o=0, align_lock_o=0, am_o=0.
- An AM arriving on the same cycle as the expected position in CHECK is the expected-position case; no double counting.

Optional Feature:
- AM_ERR_CNT_EN defined:
  - Adds output am_err_cnt_o [LANE_N*8], one 8-bit saturating counter per lane.
  - Increments on every bad expected AM while LOCKED.
  - Cleared by reset only; holds at 255.
- AM_ERR_CNT_EN undefined: the port and counters do not exist.

Decomposition:
- Package am_pkg:
  - AM byte constants per logical lane.
  - Sync header constant 2'b10.
  - State enum am_state_e {SEARCH, CHECK, LOCKED}.
  - am_match function returning hit and id.
- Sub-module am_lock_fsm: one per lane, generated LANE_N times. Contains FSM, cnt, good, bad and the optional error counter.
- Top level: instances, lane_o assembly, permutation check.

Test Plan:
- AM_PERIOD=15, identity mapping:
  - Stimulus: AMs with ids 0..3 on lanes 0..3 every 16 valid blocks.
  - Response: lane_lock_o=4'hF one cycle after the 3rd AM; lane_o=16'h8421; align_lock_o=1.
- Swapped mapping:
  - Stimulus: physical lanes carry ids 2,0,3,1.
  - Response: lane_o=16'h2814 after lock; align_lock_o=1.
- Unlock:
  - Stimulus: corrupt M0 on lane 1 for 4 consecutive expected AMs.
  - Response: after 3 bad, lane_lock_o=4'hF. After 4th, lane_lock_o[1]=0, row 1 of lane_o=0, align_lock_o=0.
  - Recovery: clean AMs relock lane 1 after 3 more.
- Stall:
  - Stimulus: deassert block_v_i for 5 cycles mid-period.
  - Response: lock retained; expected position shifts by 5 cycles; am_o stays aligned to the AM block.
- Duplicate:
  - Stimulus: lanes 0 and 1 both carry id 0; lanes 2, 3 carry ids 2, 3.
  - Response: lane_lock_o=4'hF, lane_o=16'h8411, align_lock_o=0.
- Reset mid-CHECK:
  - Stimulus: assert nreset low after the first AM.
  - Response: all outputs 0 immediately; a full 3-AM sequence is required to relock.
